// File: rtl/dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_arbiter: round-robin CPU/debug access to the data memory port, plus |
// | a clear sequencer that fills every word after reset and on request.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int              AW   = 6,
  parameter int              DW   = 32,
  parameter logic [DW-1:0]   FILL = 32'hFFFFFFFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_start,
  output logic          clr_busy,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_a,
  input  logic [DW-1:0] cpu_d,
  output logic [DW-1:0] cpu_q,
  output logic          cpu_ack,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_a,
  input  logic [DW-1:0] dbg_d,
  output logic [DW-1:0] dbg_q,
  output logic          dbg_ack,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q
);

  localparam logic [0:0]    CLEAR    = 1'b0;
  localparam logic [0:0]    IDLE     = 1'b1;
  localparam logic [AW-1:0] CNT_LAST = '1;
  localparam logic [AW-1:0] CNT_ONE  = AW'(1);

  logic [0:0]    r_state;
  logic [AW-1:0] r_clr_cnt;
  logic          r_last_gnt;

  logic w_arb_en;
  logic w_cpu_gnt;
  logic w_dbg_gnt;

  // A clear request pre-empts arbitration in the cycle it arrives.
  assign w_arb_en  = !rst && (r_state == IDLE) && !clr_start;
  assign w_cpu_gnt = w_arb_en && cpu_req && (!dbg_req || r_last_gnt);
  assign w_dbg_gnt = w_arb_en && dbg_req && (!cpu_req || !r_last_gnt);

  assign clr_busy = rst || (r_state == CLEAR);
  assign cpu_ack  = w_cpu_gnt;
  assign dbg_ack  = w_dbg_gnt;
  assign cpu_q    = mem_q;
  assign dbg_q    = mem_q;

  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_d  = '0;
    if (clr_busy) begin
      // Reset gates the write strobe so nothing is corrupted while rst is high.
      mem_we = !rst;
      mem_a  = r_clr_cnt;
      mem_d  = FILL;
    end else if (w_cpu_gnt) begin
      mem_we = cpu_we;
      mem_a  = cpu_a;
      mem_d  = cpu_d;
    end else if (w_dbg_gnt) begin
      mem_we = dbg_we;
      mem_a  = dbg_a;
      mem_d  = dbg_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= CLEAR;
      r_clr_cnt  <= '0;
      r_last_gnt <= 1'b1;
    end else begin
      case (r_state)
        CLEAR: begin
          // Counter wraps to zero on the last address, ready for the next clear.
          r_clr_cnt <= r_clr_cnt + CNT_ONE;
          if (r_clr_cnt == CNT_LAST) begin
            r_state <= IDLE;
          end
        end
        default: begin
          if (clr_start) begin
            r_state <= CLEAR;
          end else if (w_cpu_gnt) begin
            r_last_gnt <= 1'b0;
          end else if (w_dbg_gnt) begin
            r_last_gnt <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_arbiter: self-checking bench for dmem_arbiter with a memory model|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_dmem_arbiter;

  localparam int          AW    = 6;
  localparam int          DW    = 32;
  localparam int          DEPTH = 64;
  localparam logic [31:0] FILL  = 32'hFFFFFFFF;

  typedef struct packed {
    logic        creq;
    logic        cwe;
    logic [5:0]  ca;
    logic [31:0] cd;
    logic        dreq;
    logic        dwe;
    logic [5:0]  da;
    logic [31:0] dd;
    logic        cs;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        e_cack;
    logic        e_dack;
    logic        chk_q;
    logic [31:0] e_q;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr_start = 1'b0;
  logic          clr_busy;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_a = '0;
  logic [DW-1:0] cpu_d = '0;
  logic [DW-1:0] cpu_q;
  logic          cpu_ack;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_a = '0;
  logic [DW-1:0] dbg_d = '0;
  logic [DW-1:0] dbg_q;
  logic          dbg_ack;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q;

  logic [DW-1:0] mem_array [DEPTH];

  int errors = 0;
  int checks = 0;

  // Reference model state: cycles of clear still to run, round-robin memory, contents.
  int          clear_left;
  bit          last_dbg;
  logic [31:0] ref_mem [DEPTH];

  dmem_arbiter #(.AW(AW), .DW(DW), .FILL(FILL)) dut (
    .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(clr_busy),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d),
    .cpu_q(cpu_q), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_a(dbg_a), .dbg_d(dbg_d),
    .dbg_q(dbg_q), .dbg_ack(dbg_ack),
    .mem_we(mem_we), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  assign mem_q = mem_array[mem_a];
  always @(posedge clk) if (mem_we) mem_array[mem_a] <= mem_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(input logic creq, input logic cwe, input int ca, input logic [31:0] cd,
                               input logic dreq, input logic dwe, input int da, input logic [31:0] dd,
                               input logic cs);
    stim_t s;
    s.creq = creq; s.cwe = cwe; s.ca = 6'(ca); s.cd = cd;
    s.dreq = dreq; s.dwe = dwe; s.da = 6'(da); s.dd = dd;
    s.cs = cs;
    return s;
  endfunction

  // Entered just after a rising edge; drives one cycle, checks it, returns after the next edge.
  task automatic run_cycle(input stim_t s, output logic cack, output logic dack, output logic [31:0] q);
    bit g_c, g_d, in_clear;
    int caddr;
    cpu_req = s.creq; cpu_we = s.cwe; cpu_a = s.ca; cpu_d = s.cd;
    dbg_req = s.dreq; dbg_we = s.dwe; dbg_a = s.da; dbg_d = s.dd;
    clr_start = s.cs;
    #3;
    cack = cpu_ack;
    dack = dbg_ack;
    q    = cpu_ack ? cpu_q : dbg_q;
    in_clear = (clear_left > 0);
    caddr = DEPTH - clear_left;
    g_c = 1'b0;
    g_d = 1'b0;
    if (in_clear) begin
      chk("clr_busy", 64'(clr_busy), 64'd1);
      chk("clear_we", 64'(mem_we), 64'd1);
      chk("clear_addr", 64'(mem_a), 64'(caddr));
      chk("clear_data", 64'(mem_d), 64'(FILL));
      chk("clear_acks", {62'd0, cpu_ack, dbg_ack}, 64'd0);
    end else begin
      chk("clr_busy", 64'(clr_busy), 64'd0);
      if (!s.cs) begin
        g_c = s.creq && (!s.dreq || last_dbg);
        g_d = s.dreq && !g_c;
      end
      chk("cpu_ack", 64'(cpu_ack), 64'(g_c));
      chk("dbg_ack", 64'(dbg_ack), 64'(g_d));
      if (g_c) begin
        chk("cpu_mem_we", 64'(mem_we), 64'(s.cwe));
        chk("cpu_mem_a", 64'(mem_a), 64'(s.ca));
        if (!s.cwe) chk("cpu_q", 64'(cpu_q), 64'(ref_mem[s.ca]));
      end else if (g_d) begin
        chk("dbg_mem_we", 64'(mem_we), 64'(s.dwe));
        chk("dbg_mem_a", 64'(mem_a), 64'(s.da));
        if (!s.dwe) chk("dbg_q", 64'(dbg_q), 64'(ref_mem[s.da]));
      end else begin
        chk("idle_mem_we", 64'(mem_we), 64'd0);
        chk("idle_mem_a", 64'(mem_a), 64'd0);
      end
    end
    @(posedge clk);
    if (in_clear) begin
      ref_mem[caddr] = FILL;
      clear_left--;
    end else if (s.cs) begin
      clear_left = DEPTH;
    end else if (g_c) begin
      if (s.cwe) ref_mem[s.ca] = s.cd;
      last_dbg = 1'b0;
    end else if (g_d) begin
      if (s.dwe) ref_mem[s.da] = s.dd;
      last_dbg = 1'b1;
    end
    #1;
  endtask

  task automatic reset_model();
    clear_left = DEPTH;
    last_dbg   = 1'b1;
  endtask

  vec_t        vecs [$];
  stim_t       idle_s;
  logic        ca_o, da_o;
  logic [31:0] q_o;

  initial begin
    idle_s = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;

    // Reset state
    #2;
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_busy", 64'(clr_busy), 64'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Power-up clear, then a read of a=17
    for (int i = 0; i < DEPTH; i++) run_cycle(idle_s, ca_o, da_o, q_o);
    run_cycle(mk(1, 0, 17, 0, 0, 0, 0, 0, 0), ca_o, da_o, q_o);
    chk("tp1_ack", 64'(ca_o), 64'd1);
    chk("tp1_q", 64'(q_o), 64'hFFFFFFFF);

    // Table-driven sequences: write/read, contention, same-address contention
    vecs.push_back('{mk(1, 1, 5, 32'h12345678, 0, 0, 0, 0, 0), 1, 0, 0, 32'h0});
    vecs.push_back('{mk(1, 0, 5, 0, 0, 0, 0, 0, 0), 1, 0, 1, 32'h12345678});
    vecs.push_back('{mk(0, 0, 0, 0, 1, 0, 5, 0, 0), 0, 1, 1, 32'h12345678});
    for (int i = 0; i < 6; i++)
      vecs.push_back('{mk(1, 0, 1, 0, 1, 0, 2, 0, 0), (i % 2) == 0, (i % 2) == 1, 1, 32'hFFFFFFFF});
    vecs.push_back('{idle_s, 0, 0, 0, 32'h0});
    vecs.push_back('{mk(1, 0, 63, 0, 1, 1, 63, 32'hCAFEF00D, 0), 1, 0, 1, 32'hFFFFFFFF});
    vecs.push_back('{mk(0, 0, 0, 0, 1, 1, 63, 32'hCAFEF00D, 0), 0, 1, 0, 32'h0});
    vecs.push_back('{mk(1, 0, 63, 0, 0, 0, 0, 0, 0), 1, 0, 1, 32'hCAFEF00D});
    foreach (vecs[i]) begin
      run_cycle(vecs[i].s, ca_o, da_o, q_o);
      chk($sformatf("vec%0d_cack", i), 64'(ca_o), 64'(vecs[i].e_cack));
      chk($sformatf("vec%0d_dack", i), 64'(da_o), 64'(vecs[i].e_dack));
      if (vecs[i].chk_q) chk($sformatf("vec%0d_q", i), 64'(q_o), 64'(vecs[i].e_q));
    end

    // Clear request pre-empts a debug read raised in the same cycle
    run_cycle(mk(1, 1, 3, 32'h0000ABCD, 0, 0, 0, 0, 0), ca_o, da_o, q_o);
    run_cycle(mk(0, 0, 0, 0, 1, 0, 3, 0, 1), ca_o, da_o, q_o);
    chk("tp4_start_dack", 64'(da_o), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      run_cycle(mk(0, 0, 0, 0, 1, 0, 3, 0, (i == 10)), ca_o, da_o, q_o);
      chk("tp4_wait_dack", 64'(da_o), 64'd0);
    end
    run_cycle(mk(0, 0, 0, 0, 1, 0, 3, 0, 0), ca_o, da_o, q_o);
    chk("tp4_dack", 64'(da_o), 64'd1);
    chk("tp4_q", 64'(q_o), 64'hFFFFFFFF);

    // Reset in the middle of a clear
    run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), ca_o, da_o, q_o);
    for (int i = 0; i < 30; i++) run_cycle(idle_s, ca_o, da_o, q_o);
    #2;
    chk("tp5_pre_we", 64'(mem_we), 64'd1);
    chk("tp5_pre_a", 64'(mem_a), 64'd30);
    rst = 1'b1;
    #1;
    chk("tp5_rst_we", 64'(mem_we), 64'd0);
    chk("tp5_rst_busy", 64'(clr_busy), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    reset_model();
    for (int i = 0; i < DEPTH; i++) run_cycle(idle_s, ca_o, da_o, q_o);
    run_cycle(idle_s, ca_o, da_o, q_o);

    // Randomized traffic; requests are held until acknowledged
    begin
      stim_t s;
      bit    pend_c, pend_d;
      pend_c = 1'b0;
      pend_d = 1'b0;
      s = idle_s;
      for (int i = 0; i < 600; i++) begin
        if (!pend_c) begin
          s.creq = ($urandom_range(0, 3) != 0);
          s.cwe  = $urandom_range(0, 1) == 1;
          s.ca   = 6'($urandom_range(0, 7));
          s.cd   = $urandom;
        end
        if (!pend_d) begin
          s.dreq = ($urandom_range(0, 2) != 0);
          s.dwe  = $urandom_range(0, 1) == 1;
          s.da   = 6'($urandom_range(0, 7));
          s.dd   = $urandom;
        end
        s.cs = ($urandom_range(0, 79) == 0);
        run_cycle(s, ca_o, da_o, q_o);
        pend_c = s.creq && !ca_o;
        pend_d = s.dreq && !da_o;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
